// File: rtl/stream_arb_4to1.sv
// ---------------------------------------------------------------------------
// stream_arb_4to1
//
// Purpose:
//   Four-input valid/ready stream arbiter with a single registered output
//   stage. Priority rotates round-robin starting after the most recent
//   winner. An optional burst mode lets the last winner keep the grant for up
//   to BURST_LEN consecutive words while it keeps requesting.
//
// Optional feature:
//   `define STREAM_ARB_BURST_EN  -> compile burst mode in (adds burst_cnt_q)
//
// Parameters:
//   PAYLOAD_BITS   payload width of every data port
//   BURST_LEN      max consecutive grants per port in burst mode (2..15)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   val_in[3:0]     per-requester valid
//   ready_upward    per-requester ready (at most one bit set)
//   din0..din3      requester payloads
//   val_out         downstream valid (registered)
//   ready_downward  downstream ready
//   dout            downstream payload (registered)
//   src_id          index of the requester that supplied dout (registered)
// ---------------------------------------------------------------------------
module stream_arb_4to1 #(
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              val_in,
    output logic [3:0]              ready_upward,
    input  logic [PAYLOAD_BITS-1:0] din0,
    input  logic [PAYLOAD_BITS-1:0] din1,
    input  logic [PAYLOAD_BITS-1:0] din2,
    input  logic [PAYLOAD_BITS-1:0] din3,
    output logic                    val_out,
    input  logic                    ready_downward,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic [1:0]              src_id
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic                    state_q, state_d;
    logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
    logic [1:0]              src_q, src_d;
    logic [1:0]              last_q, last_d;
    logic [1:0]              winner;
    logic [1:0]              scan_idx;
    logic                    stage_free;
    logic                    transfer;
    logic [PAYLOAD_BITS-1:0] din_arr [4];

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    assign stage_free = (state_q == IDLE) | ready_downward;
    // Reset gates the grant so ready_upward is forced low while reset is high.
    assign transfer   = ~reset & stage_free & (|val_in);

`ifdef STREAM_ARB_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       burst_hold;

    // burst_cnt_q == 0 only right after reset, so the first grant always
    // comes from the ordinary scan (port 0 first).
    assign burst_hold = (burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_MAX)
                        && val_in[last_q];
`endif

    // Scan from last+1 (highest) to last+4 == last (lowest). Iterating from
    // the lowest-priority offset down lets the highest-priority hit win.
    always_comb begin
        winner   = last_q;
        scan_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            scan_idx = last_q + 2'(k);
            if (val_in[scan_idx]) begin
                winner = scan_idx;
            end
        end
`ifdef STREAM_ARB_BURST_EN
        if (burst_hold) begin
            winner = last_q;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign ready_upward[gi] = transfer & (winner == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        src_d   = src_q;
        last_d  = last_q;
        if (transfer) begin
            state_d = BUSY;
            dout_d  = din_arr[winner];
            src_d   = winner;
            last_d  = winner;
        end else if (stage_free) begin
            // Stage drained with nothing new to load: drop valid, keep data.
            state_d = IDLE;
        end
    end

`ifdef STREAM_ARB_BURST_EN
    // A repeat grant outside an active burst (e.g. the only requester
    // wrapping around after hitting the cap) starts a fresh burst.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (transfer) begin
            burst_cnt_d = burst_hold ? (burst_cnt_q + 4'd1) : 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= 4'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dout_q  <= '0;
            src_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign val_out = state_q;
    assign dout    = dout_q;
    assign src_id  = src_q;

endmodule

// File: tb/tb_stream_arb_4to1.sv
// ---------------------------------------------------------------------------
// tb_stream_arb_4to1
//
// Self-checking bench for stream_arb_4to1: a table of directed round-robin
// vectors, hand-written reset / backpressure / sparse / burst sequences, and
// a 10000-cycle random run checked against a transaction-level model with a
// word scoreboard.
// ---------------------------------------------------------------------------
module tb_stream_arb_4to1;

    localparam int PB        = 32;
    localparam int BURST_LEN = 4;
`ifdef STREAM_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    val_in = 4'b0;
    logic [3:0]    ready_upward;
    logic [PB-1:0] din [4];
    logic          val_out;
    logic          ready_downward = 1'b0;
    logic [PB-1:0] dout;
    logic [1:0]    src_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_arb_4to1 #(.PAYLOAD_BITS(PB), .BURST_LEN(BURST_LEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .val_in         (val_in),
        .ready_upward   (ready_upward),
        .din0           (din[0]),
        .din1           (din[1]),
        .din2           (din[2]),
        .din3           (din[3]),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .dout           (dout),
        .src_id         (src_id)
    );

    typedef struct packed {
        logic [3:0] vi;
        logic       rd;
        logic [3:0] exp_ru;
        logic       exp_vo;
        logic [1:0] exp_src;
    } vec_t;

    typedef struct {
        logic [1:0]    src;
        logic [PB-1:0] data;
    } word_t;

    vec_t  vec [12];
    word_t sbq [$];

    // Transaction-level model state
    bit m_val;
    int m_last;
    int m_cnt;
    int waits [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PB-1:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        val_in = 4'b0;
        ready_downward = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Rotating priority: burst owner first, else first valid after last.
    function automatic int model_winner(input logic [3:0] vi, input int last, input int cnt);
        if (BURST && cnt != 0 && cnt < BURST_LEN && vi[last]) return last;
        for (int k = 1; k <= 4; k++) begin
            if (vi[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic rand_cycle(input logic [3:0] vi, input logic rd);
        int         w;
        bit         free;
        bit         xfer;
        logic [3:0] exp_ru;
        word_t      wd;
        val_in = vi;
        ready_downward = rd;
        for (int i = 0; i < 4; i++) din[i] = $urandom;
        #4;
        w      = model_winner(vi, m_last, m_cnt);
        free   = !m_val || rd;
        xfer   = free && (w >= 0);
        exp_ru = xfer ? (4'b0001 << w) : 4'b0000;
        chk("rnd_ready", {28'b0, ready_upward}, {28'b0, exp_ru});
        chk("rnd_onehot", {31'b0, $onehot0(ready_upward)}, 32'd1);
        chk("rnd_valid", {31'b0, val_out}, {31'b0, m_val});
        if (m_val && rd) begin
            if (sbq.size() == 0) begin
                chk("rnd_sb_underflow", 32'd1, 32'd0);
            end else begin
                wd = sbq.pop_front();
                chk("rnd_sb_src", {30'b0, src_id}, {30'b0, wd.src});
                chk("rnd_sb_data", dout, wd.data);
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (!vi[p] || (xfer && w == p)) waits[p] = 0;
            else if (xfer) begin
                waits[p]++;
                if (!BURST) chk("rnd_fair", {31'b0, waits[p] > 3}, 32'd0);
            end
        end
        if (xfer) begin
            wd.src  = 2'(w);
            wd.data = din[w];
            sbq.push_back(wd);
            m_cnt  = (BURST && w == m_last && m_cnt != 0 && m_cnt < BURST_LEN) ? m_cnt + 1 : 1;
            m_last = w;
            m_val  = 1'b1;
        end else if (free) begin
            m_val = 1'b0;
        end
        tick();
    endtask

    initial begin
        int bexp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 4; i++) din[i] = pat(i);

        // ---------------- table: round-robin and idle/hold -----------------
        //            vi       rd    exp_ru   vo    src
        vec[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        vec[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        vec[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        vec[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        vec[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        vec[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
        vec[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b0, 2'd1};
        vec[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
        vec[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        vec[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        vec[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

        do_reset();
        #4;
        chk("reset_val_out", {31'b0, val_out}, 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_src", {30'b0, src_id}, 32'd0);
        chk("reset_ready", {28'b0, ready_upward}, 32'd0);
        tick();
`ifndef STREAM_ARB_BURST_EN
        for (int i = 0; i < 12; i++) begin
            val_in = vec[i].vi;
            ready_downward = vec[i].rd;
            #4;
            $display("vec %0d: vi=%b rd=%b ru=%b vo=%b src=%0d dout=%h",
                     i, vec[i].vi, vec[i].rd, ready_upward, val_out, src_id, dout);
            chk("tbl_ready", {28'b0, ready_upward}, {28'b0, vec[i].exp_ru});
            chk("tbl_val_out", {31'b0, val_out}, {31'b0, vec[i].exp_vo});
            chk("tbl_src", {30'b0, src_id}, {30'b0, vec[i].exp_src});
            if (vec[i].exp_vo) chk("tbl_dout", dout, pat(int'(vec[i].exp_src)));
            tick();
        end
`endif

        // ---------------- reset mid-BUSY -----------------------------------
        do_reset();
        val_in = 4'b0100;
        ready_downward = 1'b0;
        tick();
        val_in = 4'b1111;
        #2;
        chk("busy_before_reset", {31'b0, val_out}, 32'd1);
        reset = 1'b1;
        #1;
        $display("reset mid-busy: vo=%b dout=%h src=%0d ru=%b", val_out, dout, src_id, ready_upward);
        chk("midrst_val_out", {31'b0, val_out}, 32'd0);
        chk("midrst_dout", dout, 32'd0);
        chk("midrst_src", {30'b0, src_id}, 32'd0);
        chk("midrst_ready", {28'b0, ready_upward}, 32'd0);
        tick();
        reset = 1'b0;
        ready_downward = 1'b1;
        #4;
        chk("postrst_ready", {28'b0, ready_upward}, 32'h1);
        tick();
        #4;
        $display("post-reset grant: vo=%b src=%0d", val_out, src_id);
        chk("postrst_src", {30'b0, src_id}, 32'd0);
        chk("postrst_val", {31'b0, val_out}, 32'd1);

        // ---------------- backpressure -------------------------------------
        do_reset();
        din[2] = 32'hA5A5A5A5;
        val_in = 4'b0100;
        tick();
        val_in = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #4;
            $display("hold %0d: vo=%b dout=%h src=%0d ru=%b", c, val_out, dout, src_id, ready_upward);
            chk("bp_val_out", {31'b0, val_out}, 32'd1);
            chk("bp_dout", dout, 32'hA5A5A5A5);
            chk("bp_src", {30'b0, src_id}, 32'd2);
            chk("bp_ready", {28'b0, ready_upward}, 32'd0);
            tick();
        end
        ready_downward = 1'b1;
        #4;
        chk("bp_release_ready", {28'b0, ready_upward}, BURST ? 32'h4 : 32'h8);
        tick();
        #4;
        chk("bp_next_src", {30'b0, src_id}, BURST ? 32'd2 : 32'd3);
        din[2] = pat(2);

        // ---------------- sparse stream on port 3 --------------------------
        do_reset();
        ready_downward = 1'b1;
        for (int c = 0; c < 8; c++) begin
            val_in = (c % 2 == 0) ? 4'b1000 : 4'b0000;
            #4;
            $display("sparse %0d: vi=%b vo=%b src=%0d", c, val_in, val_out, src_id);
            chk("sparse_val_out", {31'b0, val_out}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) chk("sparse_src", {30'b0, src_id}, 32'd3);
            tick();
        end

`ifdef STREAM_ARB_BURST_EN
        // ---------------- burst ---------------------------------------------
        do_reset();
        val_in = 4'b0011;
        ready_downward = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            #4;
            $display("burst %0d: src=%0d", c, src_id);
            chk("burst_src", {30'b0, src_id}, 32'(bexp[c]));
        end
`endif

        // ---------------- random with model + scoreboard --------------------
        do_reset();
        m_val  = 1'b0;
        m_last = 3;
        m_cnt  = 0;
        for (int p = 0; p < 4; p++) waits[p] = 0;
        sbq.delete();
        for (int c = 0; c < 10000; c++) begin
            rand_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
            if (c % 1000 == 999) $display("random cycle %0d: checks=%0d errors=%0d", c + 1, checks, errors);
        end
        rand_cycle(4'b0000, 1'b1);
        rand_cycle(4'b0000, 1'b1);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
